lfsr_seq_checker: RTL and testbench
===================================

Name: lfsr_seq_checker

Overview:
- Receive-side checker for the 32-bit LFSR random stream used by the solver's random-selection logic.
- Accepts one 32-bit state word per valid cycle and predicts the next word with the same polynomial as the generator: x^32+x^22+x^2+x^1+1, left shift, feedback into LSB.
- Synchronises to the stream and reports lock, per-word errors and saturating counters.
- Used in-fabric and in benches to prove the PRNG path is intact end to end.

Parameters:
LOCK_COUNT, 4, consecutive correct predictions needed to go from VERIFY to LOCKED (>=1)
LOSS_COUNT, 3, consecutive mispredictions in LOCKED that drop lock (>=1)
CNT_W, 16, width of err_count and checked_count

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  in_data is a new stream word this cycle
in_data  input  32  LFSR state word from the generator
clear_counters  input  1  synchronous clear of err_count and checked_count
locked  output  1  checker is synchronised (state LOCKED)
err_pulse  output  1  one-cycle pulse: the previous valid word mismatched while LOCKED
zero_err  output  1  one-cycle pulse: the previous valid word was 0x00000000
err_count  output  CNT_W  saturating mismatch count while LOCKED
checked_count  output  CNT_W  saturating count of words checked while LOCKED

Behaviour:
- Single clock. Reset is synchronous and active-high.
- Reset clears the following: state=HUNT, ref=0, match_run=0, miss_run=0. All outputs are 0.
- Reset has priority over every input. Reset mid-stream discards all history.
- pred = {ref[30:0], ref[31]^ref[21]^ref[1]^ref[0]}.
- Only cycles with in_valid=1 advance the logic. When in_valid=0, all state holds and the pulses are 0.
- All outputs are registered. Response appears the cycle after the valid word.
- A zero word on in_valid asserts zero_err for 1 cycle in every state.
- HUNT:
  - Nonzero word: ref<=in_data, match_run<=0, go to VERIFY.
  - Zero word: stay in HUNT.
- VERIFY:
  - in_data==pred: ref<=in_data, match_run++. If match_run+1==LOCK_COUNT, go to LOCKED with miss_run<=0.
  - Mismatch, nonzero word: reseed with ref<=in_data, match_run<=0, stay in VERIFY.
  - Mismatch, zero word: go to HUNT.
  - No error counting in VERIFY.
- LOCKED:
  - Every valid word increments checked_count (saturating at 2^CNT_W-1).
  - Match: ref<=in_data, miss_run<=0.
  - Mismatch: err_pulse=1 next cycle, err_count increments (saturating), ref<=pred (flywheel keeps the expected sequence), miss_run++.
  - If miss_run+1==LOSS_COUNT, go to HUNT. locked falls in the same cycle err_pulse rises.
  - A zero word in LOCKED counts as a mismatch and also pulses zero_err.
- locked = (state==LOCKED), registered.
- clear_counters:
  - Zeroes err_count and checked_count on the next edge.
  - If it coincides with a counted event, clear wins: the count is 0, but err_pulse still fires.
  - Does not affect state, ref or the run counters.
- Counters hold at all-ones; they never wrap.
- Reference sequence from seed 0x00000001: 0x00000001, 0x00000003, 0x00000006, 0x0000000D, 0x0000001B, 0x00000036, …

Test Plan:
1. Reset, then feed 0x1,0x3,0x6,0xD,0x1B,0x36 on consecutive valid cycles -> locked rises the cycle after 0x1B is accepted (4 matches after seed), err_count=0, checked_count=1 after 0x36.
2. Locked on the sequence, replace one word with 0xDEADBEEF, then resume the correct sequence -> single err_pulse, err_count=1, locked stays 1, next correct word matches via the flywheel.
3. Locked, feed 3 consecutive wrong words -> err_count=3, locked drops with the third err_pulse. Then 5 correct words relock (seed + LOCK_COUNT).
4. Feed 0x00000000 in HUNT, VERIFY and LOCKED -> zero_err pulses each time. HUNT stays in HUNT, VERIFY returns to HUNT, LOCKED counts an error.
5. Insert random in_valid=0 gaps into scenario 1 -> identical lock and count results with no pulses during gaps. Assert reset mid-stream -> all outputs 0 the next cycle.
6. CNT_W=4: force 20 errors with interleaved relocks -> err_count saturates at 15. clear_counters coincident with an error -> err_count=0, err_pulse=1.

Source files
------------

// File: rtl/lfsr_seq_checker_if.sv
// Stream and status bundle between an LFSR word source and lfsr_seq_checker.
// The master drives stream words and clear requests; the slave returns lock status and counters.
interface lfsr_seq_checker_if #(
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic [31:0]      in_data;
  logic             clear_counters;
  logic             locked;
  logic             err_pulse;
  logic             zero_err;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] checked_count;

  modport master (
    output in_valid, in_data, clear_counters,
    input  locked, err_pulse, zero_err, err_count, checked_count
  );

  modport slave (
    input  in_valid, in_data, clear_counters,
    output locked, err_pulse, zero_err, err_count, checked_count
  );
endinterface

// File: rtl/lfsr_seq_checker.sv
// Receive-side checker for the 32-bit LFSR stream (x^32+x^22+x^2+x^1+1, left shift).
// Hunts for a seed, verifies LOCK_COUNT predictions, then flywheels while reporting errors.
module lfsr_seq_checker #(
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 3,
  parameter int CNT_W      = 16
) (
  input logic              clk,
  input logic              reset,
  lfsr_seq_checker_if.slave bus
);
  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int LW = $clog2(LOSS_COUNT + 1);

  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

  state_t           state, state_next;
  logic [31:0]      ref_word, ref_next;
  logic [MW-1:0]    match_run, match_next, match_inc;
  logic [LW-1:0]    miss_run, miss_next, miss_inc;
  logic [CNT_W-1:0] err_cnt, err_next, chk_cnt, chk_next;
  logic             err_p, err_p_next, zero_p, zero_next;
  logic [31:0]      pred;
  logic             is_zero, hit;

  assign pred      = {ref_word[30:0], ref_word[31] ^ ref_word[21] ^ ref_word[1] ^ ref_word[0]};
  assign is_zero   = (bus.in_data == 32'h0);
  assign hit       = (bus.in_data == pred) && !is_zero;
  assign match_inc = match_run + MW'(1);
  assign miss_inc  = miss_run + LW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= HUNT;
      ref_word  <= '0;
      match_run <= '0;
      miss_run  <= '0;
      err_cnt   <= '0;
      chk_cnt   <= '0;
      err_p     <= 1'b0;
      zero_p    <= 1'b0;
    end else begin
      state     <= state_next;
      ref_word  <= ref_next;
      match_run <= match_next;
      miss_run  <= miss_next;
      err_cnt   <= err_next;
      chk_cnt   <= chk_next;
      err_p     <= err_p_next;
      zero_p    <= zero_next;
    end
  end

  always_comb begin
    state_next = state;
    ref_next   = ref_word;
    match_next = match_run;
    miss_next  = miss_run;
    err_next   = err_cnt;
    chk_next   = chk_cnt;
    err_p_next = 1'b0;
    zero_next  = 1'b0;

    if (bus.in_valid) begin
      zero_next = is_zero;
      unique case (state)
        HUNT: begin
          if (!is_zero) begin
            ref_next   = bus.in_data;
            match_next = '0;
            state_next = VERIFY;
          end
        end
        VERIFY: begin
          if (hit) begin
            ref_next   = bus.in_data;
            match_next = match_inc;
            if (match_inc == MW'(LOCK_COUNT)) begin
              state_next = LOCKED;
              miss_next  = '0;
            end
          end else if (!is_zero) begin
            ref_next   = bus.in_data;
            match_next = '0;
          end else begin
            state_next = HUNT;
          end
        end
        LOCKED: begin
          // The reference always advances to the prediction so a corrupted word cannot derail it.
          ref_next = pred;
          chk_next = (chk_cnt == '1) ? chk_cnt : chk_cnt + CNT_W'(1);
          if (hit) begin
            miss_next = '0;
          end else begin
            err_p_next = 1'b1;
            err_next   = (err_cnt == '1) ? err_cnt : err_cnt + CNT_W'(1);
            miss_next  = miss_inc;
            if (miss_inc == LW'(LOSS_COUNT)) state_next = HUNT;
          end
        end
        default: state_next = HUNT;
      endcase
    end

    if (bus.clear_counters) begin
      err_next = '0;
      chk_next = '0;
    end
  end

  assign bus.locked        = (state == LOCKED);
  assign bus.err_pulse     = err_p;
  assign bus.zero_err      = zero_p;
  assign bus.err_count     = err_cnt;
  assign bus.checked_count = chk_cnt;
endmodule

// File: tb/tb_lfsr_seq_checker.sv
// Randomised self-checking bench for lfsr_seq_checker (CNT_W=4 so saturation is reachable).
// A word-level reference model predicts every output after every clock edge.
module tb_lfsr_seq_checker;
  localparam int LOCK_COUNT = 4;
  localparam int LOSS_COUNT = 3;
  localparam int CNT_W      = 4;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset;
  int   checkCount = 0;
  int   passCount  = 0;
  int   cycleNo    = 0;

  lfsr_seq_checker_if #(.CNT_W(CNT_W)) bus ();

  lfsr_seq_checker #(
    .LOCK_COUNT(LOCK_COUNT),
    .LOSS_COUNT(LOSS_COUNT),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Model state: 0 = hunting, 1 = verifying, 2 = locked
  int          mMode;
  logic [31:0] mRef;
  int          mMatches, mMisses, mErr, mChk;
  bit          mErrPulse, mZero;
  logic [31:0] gen;

  function automatic logic [31:0] lfsrNext(input logic [31:0] x);
    return (x << 1) | {31'h0, ^(x & 32'h8020_0003)};
  endfunction

  function automatic logic [31:0] wrongWord(input logic [31:0] correct);
    logic [31:0] w;
    do w = $urandom; while (w == correct || w == 32'h0);
    return w;
  endfunction

  task automatic modelStep(input bit rst, input bit v, input logic [31:0] d, input bit clr);
    logic [31:0] expect_word;
    if (rst) begin
      mMode = 0; mRef = 0; mMatches = 0; mMisses = 0;
      mErr = 0; mChk = 0; mErrPulse = 0; mZero = 0;
      return;
    end
    mErrPulse = 0;
    mZero     = 0;
    if (v) begin
      mZero = (d == 0);
      expect_word = lfsrNext(mRef);
      if (mMode == 0) begin
        if (d != 0) begin mRef = d; mMatches = 0; mMode = 1; end
      end else if (mMode == 1) begin
        if (d == expect_word) begin
          mRef = d;
          mMatches++;
          if (mMatches == LOCK_COUNT) begin mMode = 2; mMisses = 0; end
        end else if (d != 0) begin
          mRef = d; mMatches = 0;
        end else begin
          mMode = 0;
        end
      end else begin
        if (mChk < CNT_MAX) mChk++;
        mRef = expect_word;
        if (d == expect_word && d != 0) begin
          mMisses = 0;
        end else begin
          mErrPulse = 1;
          if (mErr < CNT_MAX) mErr++;
          mMisses++;
          if (mMisses == LOSS_COUNT) mMode = 0;
        end
      end
    end
    if (clr) begin mErr = 0; mChk = 0; end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected)
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", tag, cycleNo, observed, expected);
    else
      passCount++;
  endtask

  task automatic checkAll();
    checkOutput("locked", {31'h0, bus.locked}, {31'h0, mMode == 2});
    checkOutput("err_pulse", {31'h0, bus.err_pulse}, {31'h0, mErrPulse});
    checkOutput("zero_err", {31'h0, bus.zero_err}, {31'h0, mZero});
    checkOutput("err_count", 32'(bus.err_count), 32'(mErr));
    checkOutput("checked_count", 32'(bus.checked_count), 32'(mChk));
  endtask

  task automatic applyStimulus(input bit rst, input bit v, input logic [31:0] d, input bit clr);
    reset              = rst;
    bus.in_valid       = v;
    bus.in_data        = d;
    bus.clear_counters = clr;
    modelStep(rst, v, d, clr);
    @(posedge clk);
    #1;
    cycleNo++;
    checkAll();
  endtask

  task automatic sendGood();
    gen = lfsrNext(gen);
    applyStimulus(0, 1, gen, 0);
  endtask

  task automatic sendBad(input bit clr);
    gen = lfsrNext(gen);
    applyStimulus(0, 1, wrongWord(gen), clr);
  endtask

  initial begin
    reset = 1'b1; bus.in_valid = 1'b0; bus.in_data = '0; bus.clear_counters = 1'b0;
    applyStimulus(1, 0, 0, 0);

    // Lock on the reference sequence from seed 1
    gen = 32'h1;
    applyStimulus(0, 1, gen, 0);
    for (int i = 0; i < 3; i++) sendGood();
    checkOutput("not_yet_locked", {31'h0, bus.locked}, 32'h0);
    sendGood();
    checkOutput("gen_1b", gen, 32'h1B);
    checkOutput("lock_after_1b", {31'h0, bus.locked}, 32'h1);
    sendGood();
    checkOutput("chk_after_36", 32'(bus.checked_count), 32'h1);
    checkOutput("err_after_36", 32'(bus.err_count), 32'h0);

    // Single corrupted word, flywheel carries the lock
    gen = lfsrNext(gen);
    applyStimulus(0, 1, 32'hDEADBEEF, 0);
    checkOutput("single_err_pulse", {31'h0, bus.err_pulse}, 32'h1);
    checkOutput("single_err_count", 32'(bus.err_count), 32'h1);
    sendGood();
    checkOutput("flywheel_match", {31'h0, bus.err_pulse}, 32'h0);
    checkOutput("still_locked", {31'h0, bus.locked}, 32'h1);

    // Three consecutive errors drop lock; seed plus four matches relocks
    applyStimulus(0, 0, 32'h0, 1);
    for (int i = 0; i < 3; i++) sendBad(0);
    checkOutput("loss_err_count", 32'(bus.err_count), 32'h3);
    checkOutput("loss_unlocked", {31'h0, bus.locked}, 32'h0);
    for (int i = 0; i < 5; i++) sendGood();
    checkOutput("relocked", {31'h0, bus.locked}, 32'h1);

    // Zero words in each state
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 1, 32'h0, 0);
    applyStimulus(0, 1, 32'h1, 0);
    applyStimulus(0, 1, 32'h0, 0);
    gen = 32'h3;
    applyStimulus(0, 1, gen, 0);
    for (int i = 0; i < 4; i++) sendGood();
    checkOutput("relock_after_zero", {31'h0, bus.locked}, 32'h1);
    applyStimulus(0, 1, 32'h0, 0);
    checkOutput("zero_locked_err", {31'h0, bus.err_pulse}, 32'h1);
    gen = lfsrNext(gen);

    // Scenario 1 with random idle gaps, then mid-stream reset
    applyStimulus(1, 0, 0, 0);
    gen = 32'h1;
    applyStimulus(0, 1, gen, 0);
    for (int i = 0; i < 5; i++) begin
      repeat ($urandom_range(0, 3)) applyStimulus(0, 0, $urandom, 0);
      sendGood();
    end
    checkOutput("gap_locked", {31'h0, bus.locked}, 32'h1);
    checkOutput("gap_chk", 32'(bus.checked_count), 32'h1);
    sendBad(0);
    applyStimulus(1, 1, gen, 0);

    // Saturate err_count across repeated loss/relock cycles
    for (int k = 0; k < 7; k++) begin
      for (int i = 0; i < 5; i++) sendGood();
      for (int i = 0; i < 3; i++) sendBad(0);
    end
    checkOutput("err_saturated", 32'(bus.err_count), 32'(CNT_MAX));
    for (int i = 0; i < 5; i++) sendGood();
    sendBad(1);
    checkOutput("clear_wins_count", 32'(bus.err_count), 32'h0);
    checkOutput("clear_keeps_pulse", {31'h0, bus.err_pulse}, 32'h1);

    // Random soak
    for (int n = 0; n < 2000; n++) begin
      bit rst, v, clr;
      int kind;
      logic [31:0] d;
      rst  = ($urandom_range(0, 199) == 0);
      v    = ($urandom_range(0, 3) != 0);
      clr  = ($urandom_range(0, 49) == 0);
      kind = $urandom_range(0, 19);
      if (!v) d = $urandom;
      else if (kind == 0) d = 32'h0;
      else if (kind <= 2) begin gen = lfsrNext(gen); d = wrongWord(gen); end
      else begin gen = lfsrNext(gen); d = gen; end
      applyStimulus(rst, v, d, clr);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
